// File: rtl/dag1_result_accumulator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dag1_result_accumulator: sums DAG stage results per frame, valid/ready   |
// | Optional macro DAG1_ACC_SATURATE_EN clamps acc on carry. Rev 1.0         |
// +--------------------------------------------------------------------------+
module dag1_result_accumulator #(
    parameter int BITS      = 2,
    parameter int ACC_BITS  = 8,
    parameter int FRAME_LEN = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [BITS-1:0]     in_data,
    input  logic                in_last,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ACC_BITS-1:0] out_sum,
    output logic [7:0]          out_count,
    output logic                out_overflow
);

    localparam logic [7:0] c_FRAME_LEN = 8'(FRAME_LEN);

    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ACC_BITS-1:0] acc_q, acc_d;
    logic [7:0]          cnt_q, cnt_d;
    logic                ovf_q, ovf_d;
    logic                out_valid_q, out_valid_d;
    logic [ACC_BITS-1:0] out_sum_q, out_sum_d;
    logic [7:0]          out_count_q, out_count_d;
    logic                out_overflow_q, out_overflow_d;

    logic                w_accept;
    logic [ACC_BITS:0]   w_nxt;
    logic                w_carry;
    logic [7:0]          w_cnt_inc;
    logic                w_close;
    logic [ACC_BITS-1:0] w_acc_upd;

    assign in_ready  = (state_q == ST_ACCUM);
    assign w_accept  = in_valid & in_ready;
    assign w_nxt     = {1'b0, acc_q} + {{(ACC_BITS+1-BITS){1'b0}}, in_data};
    assign w_carry   = w_nxt[ACC_BITS];
    assign w_cnt_inc = cnt_q + 8'd1;
    assign w_close   = (w_cnt_inc == c_FRAME_LEN) | in_last;

`ifdef DAG1_ACC_SATURATE_EN
    // Once any carry has occurred in this frame the accumulator stays pinned at max.
    assign w_acc_upd = (w_carry | ovf_q) ? {ACC_BITS{1'b1}} : w_nxt[ACC_BITS-1:0];
`else
    assign w_acc_upd = w_nxt[ACC_BITS-1:0];
`endif

    always_comb begin
        state_d        = state_q;
        acc_d          = acc_q;
        cnt_d          = cnt_q;
        ovf_d          = ovf_q;
        out_valid_d    = out_valid_q;
        out_sum_d      = out_sum_q;
        out_count_d    = out_count_q;
        out_overflow_d = out_overflow_q;
        case (state_q)
            ST_ACCUM: begin
                if (w_accept) begin
                    if (w_close) begin
                        out_sum_d      = w_acc_upd;
                        out_count_d    = w_cnt_inc;
                        out_overflow_d = ovf_q | w_carry;
                        out_valid_d    = 1'b1;
                        acc_d          = '0;
                        cnt_d          = 8'd0;
                        ovf_d          = 1'b0;
                        state_d        = ST_HOLD;
                    end else begin
                        acc_d = w_acc_upd;
                        cnt_d = w_cnt_inc;
                        ovf_d = ovf_q | w_carry;
                    end
                end
            end
            ST_HOLD: begin
                if (out_valid_q & out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_ACCUM;
                end
            end
            default: state_d = ST_ACCUM;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= ST_ACCUM;
            acc_q          <= '0;
            cnt_q          <= 8'd0;
            ovf_q          <= 1'b0;
            out_valid_q    <= 1'b0;
            out_sum_q      <= '0;
            out_count_q    <= 8'd0;
            out_overflow_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            acc_q          <= acc_d;
            cnt_q          <= cnt_d;
            ovf_q          <= ovf_d;
            out_valid_q    <= out_valid_d;
            out_sum_q      <= out_sum_d;
            out_count_q    <= out_count_d;
            out_overflow_q <= out_overflow_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_sum      = out_sum_q;
    assign out_count    = out_count_q;
    assign out_overflow = out_overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_dag1_result_accumulator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_dag1_result_accumulator: frame-level model vs. 8-bit and 3-bit DUTs   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_dag1_result_accumulator;

    localparam int FRAME_LEN = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_last = 1'b0;
    logic       out_ready = 1'b0;
    logic [1:0] in_data = 2'd0;

    logic       a_in_ready, a_out_valid, a_out_overflow;
    logic [7:0] a_out_sum, a_out_count;
    logic       b_in_ready, b_out_valid, b_out_overflow;
    logic [2:0] b_out_sum;
    logic [7:0] b_out_count;

    always #5 clk = ~clk;

    dag1_result_accumulator #(.BITS(2), .ACC_BITS(8), .FRAME_LEN(FRAME_LEN)) dut_a (
        .clock(clk), .reset(rst), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(a_out_valid),
        .out_ready(out_ready), .out_sum(a_out_sum), .out_count(a_out_count),
        .out_overflow(a_out_overflow)
    );

    dag1_result_accumulator #(.BITS(2), .ACC_BITS(3), .FRAME_LEN(FRAME_LEN)) dut_b (
        .clock(clk), .reset(rst), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(b_out_valid),
        .out_ready(out_ready), .out_sum(b_out_sum), .out_count(b_out_count),
        .out_overflow(b_out_overflow)
    );

    int checks = 0;
    int errors = 0;

    // Model: samples of the open frame are queued; the result is derived from their true total.
    bit m_hold, m_valid, m_ovf8, m_ovf3;
    int m_sum8, m_sum3, m_cnt;
    int frame_q[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_hold = 0; m_valid = 0; m_ovf8 = 0; m_ovf3 = 0;
        m_sum8 = 0; m_sum3 = 0; m_cnt = 0;
        frame_q.delete();
    endtask

    task automatic model_edge(input bit r, input bit iv, input int d, input bit last, input bit ordy);
        int total;
        if (r) begin
            model_reset();
        end else if (!m_hold) begin
            if (iv) begin
                frame_q.push_back(d);
                if (frame_q.size() == FRAME_LEN || last) begin
                    total = 0;
                    foreach (frame_q[i]) total += frame_q[i];
                    m_cnt  = frame_q.size();
                    m_ovf8 = (total > 255);
                    m_ovf3 = (total > 7);
                    m_sum8 = total % 256;
`ifdef DAG1_ACC_SATURATE_EN
                    m_sum8 = m_ovf8 ? 255 : total;
                    m_sum3 = m_ovf3 ? 7 : total;
`else
                    m_sum3 = total % 8;
`endif
                    m_hold  = 1;
                    m_valid = 1;
                    frame_q.delete();
                end
            end
        end else if (ordy) begin
            m_hold  = 0;
            m_valid = 0;
        end
    endtask

    task automatic check_all();
        chk("a_in_ready",     int'(a_in_ready),     int'(!m_hold));
        chk("a_out_valid",    int'(a_out_valid),    int'(m_valid));
        chk("a_out_sum",      int'(a_out_sum),      m_sum8);
        chk("a_out_count",    int'(a_out_count),    m_cnt);
        chk("a_out_overflow", int'(a_out_overflow), int'(m_ovf8));
        chk("b_in_ready",     int'(b_in_ready),     int'(!m_hold));
        chk("b_out_valid",    int'(b_out_valid),    int'(m_valid));
        chk("b_out_sum",      int'(b_out_sum),      m_sum3);
        chk("b_out_count",    int'(b_out_count),    m_cnt);
        chk("b_out_overflow", int'(b_out_overflow), int'(m_ovf3));
    endtask

    task automatic step(input bit r, input bit iv, input int d, input bit last, input bit ordy);
        rst       = r;
        in_valid  = iv;
        in_data   = 2'(d);
        in_last   = last;
        out_ready = ordy;
        @(posedge clk);
        model_edge(r, iv, d, last, ordy);
        #1;
        check_all();
    endtask

    initial begin
        model_reset();

        // Reset then idle
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0);
        chk("lit_idle_valid", int'(a_out_valid), 0);
        chk("lit_idle_sum",   int'(a_out_sum),   0);
        chk("lit_idle_ready", int'(a_in_ready),  1);

        // Full frame 3,2,1,0
        step(0, 1, 3, 0, 1);
        step(0, 1, 2, 0, 1);
        step(0, 1, 1, 0, 1);
        step(0, 1, 0, 0, 1);
        chk("lit_full_valid", int'(a_out_valid),    1);
        chk("lit_full_sum",   int'(a_out_sum),      6);
        chk("lit_full_count", int'(a_out_count),    4);
        chk("lit_full_ovf",   int'(a_out_overflow), 0);
        chk("lit_full_hold",  int'(a_in_ready),     0);
        step(0, 0, 0, 0, 1);
        chk("lit_full_rel",   int'(a_in_ready),     1);

        // Early close
        step(0, 1, 3, 0, 0);
        step(0, 1, 3, 1, 0);
        chk("lit_early_sum",   int'(a_out_sum),   6);
        chk("lit_early_count", int'(a_out_count), 2);
        step(0, 0, 0, 0, 1);

        // Backpressure with ignored input during hold
        for (int i = 0; i < 4; i++) step(0, 1, 1, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 3, 0, 0);
        chk("lit_bp_sum",   int'(a_out_sum),   4);
        chk("lit_bp_valid", int'(a_out_valid), 1);
        step(0, 1, 3, 0, 1);
        for (int i = 0; i < 4; i++) step(0, 1, 2, 0, 0);
        chk("lit_bp_next_sum", int'(a_out_sum), 8);
        step(0, 0, 0, 0, 1);

        // Overflow on the 3-bit accumulator
        for (int i = 0; i < 3; i++) step(0, 1, 3, 0, 0);
        step(0, 1, 0, 1, 0);
`ifdef DAG1_ACC_SATURATE_EN
        chk("lit_ovf_sum3", int'(b_out_sum), 7);
`else
        chk("lit_ovf_sum3", int'(b_out_sum), 1);
`endif
        chk("lit_ovf_flag3",  int'(b_out_overflow), 1);
        chk("lit_ovf_count3", int'(b_out_count),    4);
        chk("lit_ovf_sum8",   int'(a_out_sum),      9);
        step(0, 0, 0, 0, 1);

        // Reset mid-frame discards partial samples
        step(0, 1, 3, 0, 0);
        step(0, 1, 3, 0, 0);
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 1, 0, 0);
        chk("lit_rst_sum",   int'(a_out_sum),   4);
        chk("lit_rst_count", int'(a_out_count), 4);
        chk("lit_rst_sum3",  int'(b_out_sum),   4);
        step(0, 0, 0, 0, 1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 3) != 0),
                 int'($urandom_range(0, 3)),
                 ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 2) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
